// File: rtl/lfu_buf_arbiter.sv
// Round-robin front end that shares one lfu_finder among NREQ buffer clients.
// Each operation takes one IDLE cycle for arbitration and one REF/ALLOC cycle for completion.
module lfu_buf_arbiter #(
    parameter int NREQ   = 4,
    parameter int LEN    = 2,
    parameter int FF_DLY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_alloc,
    input  logic [NREQ-1:0]     req_ref,
    input  logic [NREQ*LEN-1:0] req_ref_buf,
    output logic [NREQ-1:0]     gnt,
    output logic                gnt_alloc,
    output logic [LEN-1:0]      gnt_buf,
    output logic                busy,
    output logic                lfu_new_buf_req,
    output logic [LEN-1:0]      lfu_ref_buf_numbr,
    input  logic [LEN-1:0]      lfu_buf_num_replc
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 4 || LEN < 1 || FF_DLY < 0) begin : g_param_err
        $error("lfu_buf_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, REF, ALLOC} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  rr_ptr, rr_nxt;
    logic [IW-1:0]  win_id, win_nxt;
    logic [LEN-1:0] ref_buf, ref_buf_nxt;
    logic [LEN-1:0] last_buf, last_buf_nxt;

    logic           found;
    logic [IW-1:0]  pick;
    logic [LEN-1:0] pick_buf;
    logic           pick_alloc;
    int             idx;

    // First requester at or above rr_ptr, wrapping; alloc beats ref for the same requester.
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        pick_buf   = '0;
        pick_alloc = 1'b0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && (req_alloc[idx] || req_ref[idx])) begin
                found      = 1'b1;
                pick       = IW'(idx);
                pick_buf   = req_ref_buf[idx*LEN +: LEN];
                pick_alloc = req_alloc[idx];
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        rr_nxt            = rr_ptr;
        win_nxt           = win_id;
        ref_buf_nxt       = ref_buf;
        last_buf_nxt      = last_buf;
        gnt               = '0;
        gnt_alloc         = 1'b0;
        gnt_buf           = '0;
        lfu_new_buf_req   = 1'b0;
        // Idle cycles reference the MRU buffer so the finder's victim cannot drift.
        lfu_ref_buf_numbr = last_buf;
        unique case (state)
            IDLE: begin
                if (found) begin
                    win_nxt     = pick;
                    ref_buf_nxt = pick_buf;
                    rr_nxt      = (pick == IW'(NREQ-1)) ? '0 : pick + 1'b1;
                    state_nxt   = pick_alloc ? ALLOC : REF;
                end
            end
            REF: begin
                gnt[win_id]       = 1'b1;
                gnt_buf           = ref_buf;
                lfu_ref_buf_numbr = ref_buf;
                last_buf_nxt      = ref_buf;
                state_nxt         = IDLE;
            end
            ALLOC: begin
                lfu_new_buf_req = 1'b1;
                gnt[win_id]     = 1'b1;
                gnt_alloc       = 1'b1;
                gnt_buf         = lfu_buf_num_replc;
                last_buf_nxt    = lfu_buf_num_replc;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win_id   <= '0;
            ref_buf  <= '0;
            last_buf <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            win_id   <= win_nxt;
            ref_buf  <= ref_buf_nxt;
            last_buf <= last_buf_nxt;
        end
    end

endmodule
